lsu_ctrl: RTL and testbench

LSU_CTRL -- requirements
Module: lsu_ctrl

---
 rtl/lsu_ctrl_if.sv | 47 ++++
 rtl/lsu_ctrl.sv | 219 +++++++++++++++++++++
 tb/tb_lsu_ctrl.sv | 248 ++++++++++++++++++++++++
 3 files changed

// File: rtl/lsu_ctrl_if.sv
// Purpose: core-side and bus-side signal bundle for lsu_ctrl.
// Latency: none (wires only).
// Backpressure: none; the bus side is a request pulse answered by a response pulse.
// Ports: master = the load/store controller, slave = the core + memory bus environment.
interface lsu_ctrl_if #(
    parameter int XLEN = 32
);
    localparam int NB = XLEN / 8;

    // core side
    logic            enabled;
    logic [3:0]      op;
    logic [XLEN-1:0] vaddr;
    logic [XLEN-1:0] store_data;
    logic            completed;
    logic [XLEN-1:0] result;
    logic            flush_tlb;
    logic            exception_enable;
    logic [4:0]      exception_vec;
    logic [XLEN-1:0] exception_tval;

    // memory bus side
    logic            request_enable;
    logic            mode;
    logic [XLEN-1:0] bus_addr;
    logic [XLEN-1:0] wdata;
    logic [NB-1:0]   wstrb;
    logic            response_enable;
    logic            response_error;
    logic [XLEN-1:0] rdata;

    modport master (
        input  enabled, op, vaddr, store_data,
        input  response_enable, response_error, rdata,
        output completed, result, flush_tlb,
        output exception_enable, exception_vec, exception_tval,
        output request_enable, mode, bus_addr, wdata, wstrb
    );

    modport slave (
        output enabled, op, vaddr, store_data,
        output response_enable, response_error, rdata,
        input  completed, result, flush_tlb,
        input  exception_enable, exception_vec, exception_tval,
        input  request_enable, mode, bus_addr, wdata, wstrb
    );
endinterface

// File: rtl/lsu_ctrl.sv
// Purpose: load/store unit control: decode, alignment checks, byte-lane steering, LR/SC reservation, SFENCE.
// Latency: non-bus ops complete 1 cycle after acceptance; bus ops issue 1 cycle after acceptance, complete 1 cycle after response.
// Backpressure: one op in flight; enabled is only sampled in IDLE; a silent bus is cut off after TIMEOUT wait cycles.
// Ports: clk, rstn (async active-low), lsu (lsu_ctrl_if.master: core request/result + memory bus).
module lsu_ctrl #(
    parameter int XLEN           = 32,
    parameter bit BIG_ENDIAN_BUS = 1'b1,
    parameter int TIMEOUT        = 255
) (
    input  logic       clk,
    input  logic       rstn,
    lsu_ctrl_if.master lsu
);
    localparam int NB   = XLEN / 8;
    localparam int OFFW = $clog2(NB);
    localparam int CNTW = $clog2(TIMEOUT + 1);
    localparam logic [XLEN-1:0] LINE_MASK = {{(XLEN-OFFW){1'b1}}, {OFFW{1'b0}}};

    typedef enum logic [3:0] {
        OP_PASS, OP_LB, OP_LH, OP_LW, OP_LD, OP_LBU, OP_LHU, OP_LWU,
        OP_SB, OP_SH, OP_SW, OP_SD, OP_LR, OP_SC, OP_SFENCE, OP_RSVD
    } op_e;

    typedef enum logic {S_IDLE, S_WAIT} state_e;

    localparam logic [4:0] EXC_ILLEGAL  = 5'd2;
    localparam logic [4:0] EXC_LD_MISAL = 5'd4;
    localparam logic [4:0] EXC_LD_FAULT = 5'd5;
    localparam logic [4:0] EXC_ST_MISAL = 5'd6;
    localparam logic [4:0] EXC_ST_FAULT = 5'd7;

    state_e          state;
    op_e             op_q;
    logic [XLEN-1:0] vaddr_q;
    logic [CNTW-1:0] wait_cnt;
    logic            rsv_vld;
    logic [XLEN-1:0] rsv_addr;

    function automatic logic [3:0] size_of(input op_e o);
        case (o)
            OP_LB, OP_LBU, OP_SB: return 4'd1;
            OP_LH, OP_LHU, OP_SH: return 4'd2;
            OP_LW, OP_LWU, OP_SW: return 4'd4;
            OP_LD, OP_SD:         return 4'd8;
            OP_LR, OP_SC:         return 4'(NB);
            default:              return 4'd0;
        endcase
    endfunction

    // Bus lane carrying address byte offset 'off'; NB is a power of two so ~off == NB-1-off.
    function automatic logic [OFFW-1:0] lane_of(input logic [OFFW-1:0] off);
        return BIG_ENDIAN_BUS ? ~off : off;
    endfunction

    // ---------------- decode of the operation being offered ----------------
    op_e             op_in;
    logic [3:0]      in_size;
    logic            in_load, in_store, in_illegal, in_misal;
    logic [XLEN-1:0] in_line;
    logic [NB-1:0]   st_strb;
    logic [XLEN-1:0] st_data;

    assign op_in = op_e'(lsu.op);

    always_comb begin
        in_size    = size_of(op_in);
        in_load    = op_in inside {OP_LB, OP_LH, OP_LW, OP_LD, OP_LBU, OP_LHU, OP_LWU, OP_LR};
        in_store   = op_in inside {OP_SB, OP_SH, OP_SW, OP_SD, OP_SC};
        // Op 15 is treated as illegal at every width; 64-bit-only ops are illegal on a 32-bit core.
        in_illegal = (op_in == OP_RSVD) ||
                     ((XLEN == 32) && (op_in inside {OP_LD, OP_SD, OP_LWU}));
        // size is a power of two, so (size-1) masks the offset bits that must be zero
        in_misal   = (in_load || in_store) &&
                     ((lsu.vaddr[2:0] & (in_size[2:0] - 3'd1)) != 3'd0);
        in_line    = lsu.vaddr & LINE_MASK;
        st_strb    = '0;
        st_data    = '0;
        for (int i = 0; i < NB; i++) begin
            if (i < int'(in_size) && int'(lsu.vaddr[OFFW-1:0]) + i < NB) begin
                st_strb[lane_of(lsu.vaddr[OFFW-1:0] + OFFW'(i))] = 1'b1;
                st_data[{lane_of(lsu.vaddr[OFFW-1:0] + OFFW'(i)), 3'b000} +: 8] =
                    lsu.store_data[8*i +: 8];
            end
        end
    end

    // ---------------- load data assembly from the latched operation ----------------
    logic [3:0]      q_size;
    logic [XLEN-1:0] ld_raw, ld_val;
    logic            ld_ext, ld_sbit;

    always_comb begin
        q_size = size_of(op_q);
        ld_raw = '0;
        for (int i = 0; i < NB; i++) begin
            if (i < int'(q_size) && int'(vaddr_q[OFFW-1:0]) + i < NB) begin
                ld_raw[8*i +: 8] =
                    lsu.rdata[{lane_of(vaddr_q[OFFW-1:0] + OFFW'(i)), 3'b000} +: 8];
            end
        end
        ld_ext  = 1'b0;
        ld_sbit = 1'b0;
        case (op_q)
            OP_LB:   begin ld_ext = 1'b1; ld_sbit = ld_raw[7];  end
            OP_LH:   begin ld_ext = 1'b1; ld_sbit = ld_raw[15]; end
            OP_LW:   begin ld_ext = 1'b1; ld_sbit = ld_raw[31]; end
            default: ;
        endcase
        // unsigned loads are already zero-extended by ld_raw's default
        ld_val = ld_raw;
        if (ld_ext) begin
            for (int b = 8; b < XLEN; b++) begin
                if (b >= 8 * int'(q_size)) ld_val[b] = ld_sbit;
            end
        end
    end

    // ---------------- control FSM with registered outputs ----------------
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state                <= S_IDLE;
            op_q                 <= OP_PASS;
            vaddr_q              <= '0;
            wait_cnt             <= '0;
            rsv_vld              <= 1'b0;
            rsv_addr             <= '0;
            lsu.completed        <= 1'b0;
            lsu.result           <= '0;
            lsu.flush_tlb        <= 1'b0;
            lsu.exception_enable <= 1'b0;
            lsu.exception_vec    <= '0;
            lsu.exception_tval   <= '0;
            lsu.request_enable   <= 1'b0;
            lsu.mode             <= 1'b0;
            lsu.bus_addr         <= '0;
            lsu.wdata            <= '0;
            lsu.wstrb            <= '0;
        end else begin
            lsu.completed      <= 1'b0;
            lsu.request_enable <= 1'b0;
            lsu.flush_tlb      <= 1'b0;
            case (state)
                S_IDLE: begin
                    // responses arriving here (late or stray) are deliberately ignored
                    if (lsu.enabled) begin
                        op_q     <= op_in;
                        vaddr_q  <= lsu.vaddr;
                        wait_cnt <= '0;
                        if (in_illegal) begin
                            lsu.completed        <= 1'b1;
                            lsu.exception_enable <= 1'b1;
                            lsu.exception_vec    <= EXC_ILLEGAL;
                            lsu.exception_tval   <= '0;
                        end else if (in_misal) begin
                            lsu.completed        <= 1'b1;
                            lsu.exception_enable <= 1'b1;
                            lsu.exception_vec    <= in_store ? EXC_ST_MISAL : EXC_LD_MISAL;
                            lsu.exception_tval   <= lsu.vaddr;
                        end else begin
                            lsu.exception_enable <= 1'b0;
                            lsu.exception_vec    <= '0;
                            lsu.exception_tval   <= '0;
                            case (op_in)
                                OP_PASS: begin
                                    lsu.result    <= lsu.store_data;
                                    lsu.completed <= 1'b1;
                                end
                                OP_SFENCE: begin
                                    lsu.flush_tlb <= 1'b1;
                                    lsu.completed <= 1'b1;
                                    rsv_vld       <= 1'b0;
                                end
                                default: begin
                                    if (op_in == OP_SC) rsv_vld <= 1'b0;
                                    if (op_in == OP_SC && !(rsv_vld && rsv_addr == in_line)) begin
                                        lsu.result    <= XLEN'(1);
                                        lsu.completed <= 1'b1;
                                    end else begin
                                        // store data is steered into wdata here, so wdata
                                        // doubles as the latched copy of store_data
                                        lsu.request_enable <= 1'b1;
                                        lsu.mode           <= in_store;
                                        lsu.bus_addr       <= in_line;
                                        lsu.wdata          <= in_store ? st_data : '0;
                                        lsu.wstrb          <= in_store ? st_strb : '0;
                                        state              <= S_WAIT;
                                    end
                                end
                            endcase
                        end
                    end
                end
                S_WAIT: begin
                    if (lsu.response_enable || wait_cnt == CNTW'(TIMEOUT - 1)) begin
                        lsu.completed <= 1'b1;
                        state         <= S_IDLE;
                        if (!lsu.response_enable || lsu.response_error) begin
                            lsu.exception_enable <= 1'b1;
                            lsu.exception_vec    <= lsu.mode ? EXC_ST_FAULT : EXC_LD_FAULT;
                            lsu.exception_tval   <= vaddr_q;
                        end else if (!lsu.mode) begin
                            lsu.result <= ld_val;
                            if (op_q == OP_LR) begin
                                rsv_vld  <= 1'b1;
                                rsv_addr <= lsu.bus_addr;
                            end
                        end else if (op_q == OP_SC) begin
                            lsu.result <= '0;
                        end
                        if (lsu.mode && rsv_addr == lsu.bus_addr) rsv_vld <= 1'b0;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_lsu_ctrl.sv
// Purpose: randomized + directed bench for lsu_ctrl against a byte-level reference model.
// Latency: drives one operation at a time, checks every cycle until completion and beyond.
// Backpressure: bus responses are injected in a chosen wait cycle, including after timeout.
module tb_lsu_ctrl;
    localparam int TMO = 4;

    logic clk;
    logic rstn;
    int   n_checks;
    int   n_fail;

    lsu_ctrl_if #(.XLEN(32)) bif ();

    lsu_ctrl #(.XLEN(32), .BIG_ENDIAN_BUS(1'b1), .TIMEOUT(TMO)) dut (
        .clk  (clk),
        .rstn (rstn),
        .lsu  (bif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // reference model state
    bit          rsv_v;
    logic [31:0] rsv_a;
    logic [31:0] m_result;
    bit          m_exc;
    logic [4:0]  m_vec;
    logic [31:0] m_tval;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic chk_arch(input string pfx);
        chk({pfx, "_result"}, 64'(bif.result), 64'(m_result));
        chk({pfx, "_exc_en"}, 64'(bif.exception_enable), 64'(m_exc));
        chk({pfx, "_exc_vec"}, 64'(bif.exception_vec), 64'(m_vec));
        chk({pfx, "_exc_tval"}, 64'(bif.exception_tval), 64'(m_tval));
    endtask

    function automatic int op_size(input logic [3:0] o);
        case (o)
            4'd1, 4'd5, 4'd8:  return 1;
            4'd2, 4'd6, 4'd9:  return 2;
            4'd3, 4'd7, 4'd10: return 4;
            4'd4, 4'd11:       return 8;
            4'd12, 4'd13:      return 4;
            default:           return 0;
        endcase
    endfunction

    // One full operation. Call at posedge+1. rsp_cyc: wait cycle (1 = the request cycle)
    // in which the bus answers; values above TMO answer after the timeout.
    task automatic do_op(input logic [3:0] o, input logic [31:0] va, input logic [31:0] sd,
                         input int rsp_cyc, input bit rsp_err, input logic [31:0] rd);
        int          sz, a, done_cyc;
        bit          is_ld, is_st, ill, mis, bus, flush, timed;
        logic [31:0] line, e_wdata, ld_v;
        logic [3:0]  e_strb;
        logic [7:0]  b;
        sz    = op_size(o);
        is_ld = o inside {4'd1, 4'd2, 4'd3, 4'd5, 4'd6, 4'd7, 4'd12};
        is_st = o inside {4'd8, 4'd9, 4'd10, 4'd11, 4'd13};
        ill   = (o == 4'd15) || (o == 4'd4) || (o == 4'd7) || (o == 4'd11);
        mis   = (is_ld || is_st) && ((int'(va[2:0]) % sz) != 0);
        a     = int'(va[1:0]);
        line  = {va[31:2], 2'b00};
        // big-endian bus: address offset k lives in byte lane 3-k
        e_strb = '0; e_wdata = '0; ld_v = '0;
        for (int i = 0; i < sz && a + i < 4; i++) begin
            e_strb[3 - (a + i)] = 1'b1;
            e_wdata[8 * (3 - (a + i)) +: 8] = sd[8 * i +: 8];
            b = rd[8 * (3 - (a + i)) +: 8];
            ld_v = ld_v | (32'(b) << (8 * i));
        end
        if ((o inside {4'd1, 4'd2, 4'd3}) && sz < 4 && ld_v[8 * sz - 1])
            ld_v = ld_v | ~((32'd1 << (8 * sz)) - 32'd1);

        bus = 1'b0; flush = 1'b0;
        if (ill) begin
            m_exc = 1'b1; m_vec = 5'd2; m_tval = '0;
        end else if (mis) begin
            m_exc = 1'b1; m_vec = is_st ? 5'd6 : 5'd4; m_tval = va;
        end else begin
            m_exc = 1'b0; m_vec = '0; m_tval = '0;
            if (o == 4'd0) m_result = sd;
            else if (o == 4'd14) begin flush = 1'b1; rsv_v = 1'b0; end
            else if (o == 4'd13) begin
                bus   = rsv_v && (rsv_a == line);
                rsv_v = 1'b0;
                if (!bus) m_result = 32'd1;
            end else bus = 1'b1;
        end

        bif.enabled = 1'b1; bif.op = o; bif.vaddr = va; bif.store_data = sd;
        @(posedge clk); #1;
        // scramble operands: the DUT must work from what it latched
        bif.enabled = 1'b0; bif.op = 4'($urandom); bif.vaddr = $urandom; bif.store_data = $urandom;

        if (!bus) begin
            chk("imm_req", 64'(bif.request_enable), 64'd0);
            chk("imm_done", 64'(bif.completed), 64'd1);
            chk("imm_flush", 64'(bif.flush_tlb), 64'(flush));
            chk_arch("imm");
            @(posedge clk); #1;
            chk("imm_done_end", 64'(bif.completed), 64'd0);
            chk("imm_flush_end", 64'(bif.flush_tlb), 64'd0);
            return;
        end

        chk("req_pulse", 64'(bif.request_enable), 64'd1);
        chk("req_done0", 64'(bif.completed), 64'd0);
        chk("req_addr", 64'(bif.bus_addr), 64'(line));
        chk("req_mode", 64'(bif.mode), 64'(is_st));
        if (is_st) begin
            chk("req_wstrb", 64'(bif.wstrb), 64'(e_strb));
            chk("req_wdata", 64'(bif.wdata), 64'(e_wdata));
        end
        timed    = rsp_cyc > TMO;
        done_cyc = timed ? TMO : rsp_cyc;
        for (int k = 1; k <= done_cyc; k++) begin
            bif.response_enable = (k == rsp_cyc);
            bif.response_error  = rsp_err;
            bif.rdata           = (k == rsp_cyc) ? rd : $urandom;
            bif.enabled         = 1'($urandom);   // must be ignored while waiting
            @(posedge clk); #1;
            bif.response_enable = 1'b0;
            bif.enabled         = 1'b0;
            chk("wait_req", 64'(bif.request_enable), 64'd0);
            if (k < done_cyc) chk("wait_done0", 64'(bif.completed), 64'd0);
        end
        chk("bus_done", 64'(bif.completed), 64'd1);
        if (timed || rsp_err) begin
            m_exc = 1'b1; m_vec = is_st ? 5'd7 : 5'd5; m_tval = va;
        end else if (is_ld) begin
            m_result = ld_v;
            if (o == 4'd12) begin rsv_v = 1'b1; rsv_a = line; end
        end else if (o == 4'd13) m_result = '0;
        if (is_st && rsv_a == line) rsv_v = 1'b0;
        chk_arch("bus");
        // pulse must end; a response after timeout lands in IDLE and is ignored
        for (int k = done_cyc + 1; k <= (timed ? rsp_cyc : done_cyc + 1); k++) begin
            bif.response_enable = (k == rsp_cyc);
            bif.rdata           = $urandom;
            @(posedge clk); #1;
            bif.response_enable = 1'b0;
            chk("post_done0", 64'(bif.completed), 64'd0);
            chk("post_req0", 64'(bif.request_enable), 64'd0);
        end
        if (timed) chk_arch("late");
    endtask

    initial begin
        n_checks = 0; n_fail = 0;
        rsv_v = 1'b0; rsv_a = '0; m_result = '0; m_exc = 1'b0; m_vec = '0; m_tval = '0;
        rstn = 1'b0;
        bif.enabled = 1'b0; bif.op = '0; bif.vaddr = '0; bif.store_data = '0;
        bif.response_enable = 1'b0; bif.response_error = 1'b0; bif.rdata = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_done", 64'(bif.completed), 64'd0);
        chk("rst_req", 64'(bif.request_enable), 64'd0);
        chk("rst_flush", 64'(bif.flush_tlb), 64'd0);
        chk("rst_addr", 64'(bif.bus_addr), 64'd0);
        chk("rst_wstrb", 64'(bif.wstrb), 64'd0);
        chk_arch("rst");
        @(negedge clk) rstn = 1'b1;
        @(posedge clk); #1;

        // byte store on a big-endian bus
        do_op(4'd8, 32'h1001, 32'h0000_00AB, 1, 1'b0, 32'h0);
        chk("sb_addr_lit", 64'(bif.bus_addr), 64'h1000);
        chk("sb_strb_lit", 64'(bif.wstrb), 64'b0100);
        chk("sb_wdata_lit", 64'(bif.wdata), 64'h00AB_0000);
        // halfword loads, signed and unsigned
        do_op(4'd2, 32'h2002, 32'h0, 2, 1'b0, 32'h1122_80FF);
        chk("lh_lit", 64'(bif.result), 64'hFFFF_FF80);
        do_op(4'd6, 32'h2002, 32'h0, 1, 1'b0, 32'h1122_80FF);
        chk("lhu_lit", 64'(bif.result), 64'h0000_FF80);
        // misaligned word load, then an RV64-only op
        do_op(4'd3, 32'h3001, 32'h0, 1, 1'b0, 32'h0);
        chk("lw_mis_vec_lit", 64'(bif.exception_vec), 64'd4);
        chk("lw_mis_tval_lit", 64'(bif.exception_tval), 64'h3001);
        do_op(4'd11, 32'h3000, 32'h5, 1, 1'b0, 32'h0);
        chk("sd_ill_vec_lit", 64'(bif.exception_vec), 64'd2);
        // LR/SC pairs
        do_op(4'd12, 32'h40, 32'h0, 1, 1'b0, 32'hCAFE_F00D);
        do_op(4'd13, 32'h40, 32'h1234_5678, 1, 1'b0, 32'h0);
        chk("sc_win_lit", 64'(bif.result), 64'd0);
        do_op(4'd13, 32'h40, 32'h1234_5678, 1, 1'b0, 32'h0);
        chk("sc_again_lit", 64'(bif.result), 64'd1);
        do_op(4'd12, 32'h40, 32'h0, 2, 1'b0, 32'h0BAD_0BAD);
        do_op(4'd10, 32'h40, 32'h7777_7777, 1, 1'b0, 32'h0);
        do_op(4'd13, 32'h40, 32'h1, 1, 1'b0, 32'h0);
        chk("sc_after_sw_lit", 64'(bif.result), 64'd1);
        // timeout with a late response, then an erroring store
        do_op(4'd3, 32'h60, 32'h0, TMO + 2, 1'b0, 32'h55AA_55AA);
        chk("tmo_vec_lit", 64'(bif.exception_vec), 64'd5);
        do_op(4'd10, 32'h64, 32'hDEAD_BEEF, 2, 1'b1, 32'h0);
        chk("st_err_vec_lit", 64'(bif.exception_vec), 64'd7);

        // randomized traffic around a few lines to exercise the reservation
        for (int n = 0; n < 300; n++) begin
            logic [3:0] o;
            if ($urandom_range(0, 2) == 0) begin
                case ($urandom_range(0, 3))
                    0:       o = 4'd12;
                    1:       o = 4'd13;
                    2:       o = 4'd10;
                    default: o = 4'd14;
                endcase
            end else o = 4'($urandom_range(0, 15));
            do_op(o, 32'h40 + 32'($urandom_range(0, 11)), $urandom,
                  $urandom_range(1, TMO + 2), ($urandom_range(0, 9) == 0), $urandom);
        end

        // reset while waiting on the bus
        bif.enabled = 1'b1; bif.op = 4'd3; bif.vaddr = 32'h50;
        @(posedge clk); #1;
        bif.enabled = 1'b0;
        chk("rw_req", 64'(bif.request_enable), 64'd1);
        @(posedge clk); #2;
        rstn = 1'b0;
        #1;
        chk("rw_done", 64'(bif.completed), 64'd0);
        chk("rw_req0", 64'(bif.request_enable), 64'd0);
        chk("rw_addr", 64'(bif.bus_addr), 64'd0);
        chk("rw_mode", 64'(bif.mode), 64'd0);
        m_result = '0; m_exc = 1'b0; m_vec = '0; m_tval = '0; rsv_v = 1'b0;
        chk_arch("rw");
        @(posedge clk); #1;
        rstn = 1'b1;
        bif.response_enable = 1'b1; bif.response_error = 1'b0; bif.rdata = 32'hFFFF_FFFF;
        @(posedge clk); #1;
        bif.response_enable = 1'b0;
        chk("rw_late_done", 64'(bif.completed), 64'd0);
        chk_arch("rw_late");
        do_op(4'd14, 32'h0, 32'h0, 1, 1'b0, 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
